vedic_multiplier_4bit: RTL and testbench
========================================

# vedic_multiplier_4bit

Unsigned 4×4-bit multiplier built on the Urdhva-Tiryagbhyam (vertical-and-crosswise) Vedic decomposition. Four 2×2 Vedic partial products are combined by adders into an 8-bit product, which is registered once. It is the leaf arithmetic block that wider cascaded Vedic multipliers (8/16-bit) instantiate four at a time.

## Interface
Parameters:
- None. Widths are fixed: 4-bit operands, 8-bit product.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  a/b carry a valid operand pair this cycle.
- a  input  4  unsigned multiplicand.
- b  input  4  unsigned multiplier.
- out  output  8  registered unsigned product a*b.
- out_valid  output  1  out holds the product of the operands that were presented with in_valid one cycle earlier.

## Operation
- Split the operands: aL=a[1:0], aH=a[3:2], bL=b[1:0], bH=b[3:2].
- Form four 2×2 partial products, each 4 bits wide: q0=aL*bL, q1=aH*bL, q2=aL*bH, q3=aH*bH.
- Each 2×2 product uses only AND gates plus two half adders:
  - p[0]=x0&y0.
  - {c1,p[1]} = (x1&y0)+(x0&y1).
  - {p[3],p[2]} = (x1&y1)+c1.
- Combine the partial products:
  - out[1:0] = q0[1:0].
  - s1 = q1 + q2, 5 bits.
  - s2 = s1 + {q3, q0[3:2]}, 6 bits.
  - out[7:2] = s2.
- Combined, this equals a*b exactly. The maximum value is 15*15=225, so nothing overflows 8 bits.
- The multiplier holds no other state; there is no accumulation and no back-pressure.
- When in_valid=0, the output register is not updated: out holds its last value and out_valid goes low.

## Timing
- Latency is 1 cycle. Operands sampled at edge N appear on out at edge N, readable during cycle N+1.
- Throughput is one product per cycle; back-to-back in_valid is fully supported.
- Reset: while rst_n=0 at a rising edge, out←8'h00 and out_valid←0, overriding in_valid.
- Reset is synchronous only; asserting rst_n between edges has no effect until the next edge.
- Reset arriving in the middle of a stream drops any in-flight product. The first valid result after release comes one cycle after the first in_valid that is sampled with rst_n=1.
- The combinational path a/b → out register is limited to 2 AND levels, the 2×2 half adders, and two ≤6-bit ripple additions.

## Structure
- Sub-module vedic_mult_2bit: combinational only; inputs x[1:0] and y[1:0], output p[3:0]. It is instantiated four times.
- The top level contains the two adder stages, the output register and the valid register.
- Shared package vedic_pkg holds:
  - localparams VEDIC_OP_W=4 and VEDIC_PROD_W=8;
  - a half-adder function, reused by the 8/16-bit cascades.
- No typedefs are required.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=15, b=15 → out=0x00 and out_valid=0 throughout; after release, out=225 one cycle later.
- Directed products, one per cycle with in_valid=1:
  - 3*5 → 15.
  - 10*6 → 60.
  - 15*15 → 225.
  - Each result appears exactly one cycle after its operands, and out_valid=1 on each.
- Zero and identity:
  - 0*13 → 0.
  - 13*0 → 0.
  - 1*9 → 9.
  - 9*1 → 9.
- Hold behaviour: valid 7*7 (→49), then in_valid=0 with a=2, b=2 → out stays 49 and out_valid=0.
- Exhaustive sweep: all 256 (a,b) pairs streamed back-to-back → every out equals a*b against a reference model, and out_valid stays high continuously.
- Mid-stream reset: stream 4*4, then 5*5, and assert rst_n=0 in the 5*5 cycle → out=0 and out_valid=0 on the next edge; no 25 is ever reported.

Source files
------------

// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared widths and half-adder helper for the Vedic multiplier family
package vedic_pkg;

    localparam int VEDIC_OP_W   = 4;
    localparam int VEDIC_PROD_W = 8;

    // Returns {carry, sum} of two single bits.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

endpackage

// File: rtl/vedic_mult_2bit.sv
// rtl/vedic_mult_2bit.sv - combinational 2x2 vertical-and-crosswise multiplier
module vedic_mult_2bit
    import vedic_pkg::*;
(
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);

    logic [1:0] ha_mid;
    logic [1:0] ha_top;

    // Crosswise terms into the first half adder, its carry joins the vertical high term.
    always_comb begin
        ha_mid = half_add(x[1] & y[0], x[0] & y[1]);
        ha_top = half_add(x[1] & y[1], ha_mid[1]);
        p      = {ha_top, ha_mid[0], x[0] & y[0]};
    end

endmodule

// File: rtl/vedic_multiplier_4bit.sv
// rtl/vedic_multiplier_4bit.sv - registered 4x4 unsigned Vedic multiplier
module vedic_multiplier_4bit
    import vedic_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [VEDIC_OP_W-1:0]   a,
    input  logic [VEDIC_OP_W-1:0]   b,
    output logic [VEDIC_PROD_W-1:0] out,
    output logic                    out_valid
);

    logic [3:0]              q0, q1, q2, q3;
    logic [4:0]              s1;
    logic [5:0]              s2;
    logic [VEDIC_PROD_W-1:0] out_d, out_q;
    logic                    out_valid_d, out_valid_q;

    vedic_mult_2bit u_q0 (.x(a[1:0]), .y(b[1:0]), .p(q0));
    vedic_mult_2bit u_q1 (.x(a[3:2]), .y(b[1:0]), .p(q1));
    vedic_mult_2bit u_q2 (.x(a[1:0]), .y(b[3:2]), .p(q2));
    vedic_mult_2bit u_q3 (.x(a[3:2]), .y(b[3:2]), .p(q3));

    // Cross terms share weight 4; the high and low products' upper bits align with them.
    always_comb begin
        s1          = {1'b0, q1} + {1'b0, q2};
        s2          = {1'b0, s1} + {q3, q0[3:2]};
        out_d       = {s2, q0[1:0]};
        out_valid_d = in_valid;
    end

    // Product register loads only on valid operands; reset clears both product and valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (in_valid) begin
                out_q <= out_d;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vedic_multiplier_4bit.sv
// tb/tb_vedic_multiplier_4bit.sv - self-checking bench for vedic_multiplier_4bit
module tb_vedic_multiplier_4bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [7:0] out;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_out = '0;
    logic       m_valid = 1'b0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [7];

    vedic_multiplier_4bit dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .a(a),
        .b(b),
        .out(out),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // Drive one cycle of stimulus, advance the reference model, compare both outputs.
    task automatic cycle(input logic r, input logic v, input logic [3:0] x,
                         input logic [3:0] y, input string nm);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        if (!r) begin
            m_out   = 8'd0;
            m_valid = 1'b0;
        end else begin
            m_valid = v;
            if (v) m_out = 8'(int'(x) * int'(y));
        end
        check({nm, "_out"}, int'(out), int'(m_out));
        check({nm, "_valid"}, int'(out_valid), int'(m_valid));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{4'd3,  4'd5,  8'd15};
        tbl[1] = '{4'd10, 4'd6,  8'd60};
        tbl[2] = '{4'd15, 4'd15, 8'd225};
        tbl[3] = '{4'd0,  4'd13, 8'd0};
        tbl[4] = '{4'd13, 4'd0,  8'd0};
        tbl[5] = '{4'd1,  4'd9,  8'd9};
        tbl[6] = '{4'd9,  4'd1,  8'd9};

        // Reset held with valid 15*15 on the inputs.
        cycle(1'b0, 1'b1, 4'd15, 4'd15, "rst0");
        cycle(1'b0, 1'b1, 4'd15, 4'd15, "rst1");
        cycle(1'b1, 1'b1, 4'd15, 4'd15, "rel");
        check("rel_225", int'(out), 225);

        // Directed products back to back, against constant expectations.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 1'b1, tbl[i].a, tbl[i].b, "dir");
            check("dir_const", int'(out), int'(tbl[i].exp));
            check("dir_vld", int'(out_valid), 1);
        end

        // Hold: valid 7*7, then idle with different operands.
        cycle(1'b1, 1'b1, 4'd7, 4'd7, "h49");
        cycle(1'b1, 1'b0, 4'd2, 4'd2, "hold");
        check("hold_const", int'(out), 49);
        check("hold_vld", int'(out_valid), 0);

        // Reset dropped between edges must not act before the next edge.
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'd3;
        b        = 4'd3;
        #1;
        check("async_none", int'(out), 49);
        @(posedge clk);
        #1;
        m_out   = 8'd0;
        m_valid = 1'b0;
        check("sync_rst_out", int'(out), 0);
        check("sync_rst_vld", int'(out_valid), 0);

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'b1, 4'(i >> 4), 4'(i & 15), "sweep");
        end

        // Mid-stream reset on the 5*5 cycle: 25 must never appear.
        cycle(1'b1, 1'b1, 4'd4, 4'd4, "ms16");
        check("ms16_const", int'(out), 16);
        cycle(1'b0, 1'b1, 4'd5, 4'd5, "ms_rst");
        check("ms_not25", int'(out == 8'd25), 0);
        cycle(1'b1, 1'b0, 4'd5, 4'd5, "ms_after");
        check("ms_after_not25", int'(out == 8'd25), 0);

        // Randomized traffic with random valid and occasional reset.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 19) != 0), 1'($urandom), 4'($urandom), 4'($urandom), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
